// File: rtl/ahb_intc_pkg.sv
// AHB interrupt controller shared definitions.
// Bus constants, register map and data-phase bundle.
package ahb_intc_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [4:0] OFF_ENABLE   = 5'h00;
  localparam logic [4:0] OFF_PENDING  = 5'h04;
  localparam logic [4:0] OFF_TRIGGER  = 5'h08;
  localparam logic [4:0] OFF_CLAIM    = 5'h0C;
  localparam logic [4:0] OFF_COMPLETE = 5'h10;
  localparam logic [4:0] OFF_INSVC    = 5'h14;

  localparam int NUM_SRC_DEF = 8;

  typedef struct packed {
    logic       valid;
    logic       write;
    logic [4:0] off;
  } dphase_t;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index priority encoder.
// Picks the smallest set bit of the request vector.
module intc_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [4:0]   o_id
);

  // scan from the top so the lowest set index is written last
  always_comb begin
    o_valid = |i_req;
    o_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_id = 5'(i);
    end
  end

endmodule

// File: rtl/ahb_intc.sv
// AHB-Lite interrupt controller, zero wait state.
// Edge/level sources, claim/complete, registered irq.
module ahb_intc
  import ahb_intc_pkg::*;
#(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int NUM_SRC = NUM_SRC_DEF
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel_i,
  input  logic              hwrite_i,
  input  logic              hready_i,
  input  logic [2:0]        hsize_i,
  input  logic [2:0]        hburst_i,
  input  logic [1:0]        htrans_i,
  input  logic [AWIDTH-1:0] haddr_i,
  input  logic [DWIDTH-1:0] hwdata_i,
  output logic              hreadyout_o,
  output logic              hresp_o,
  output logic [DWIDTH-1:0] hrdata_o,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic              irq_o
);

  dphase_t r_dp;

  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_trigger;
  logic [NUM_SRC-1:0] r_epend;
  logic [NUM_SRC-1:0] r_insvc;
  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] r_src_prev;
  logic               r_irq;

  logic               w_accept;
  logic               w_wr;
  logic               w_rd;
  logic               w_claim;
  logic               w_complete;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_pend;
  logic [NUM_SRC-1:0] w_claimable;
  logic [NUM_SRC-1:0] w_pclr;
  logic [NUM_SRC-1:0] w_clm_set;
  logic [NUM_SRC-1:0] w_cmp_clr;
  logic [NUM_SRC-1:0] w_epend_nxt;
  logic [NUM_SRC-1:0] w_insvc_nxt;
  logic               w_win_vld;
  logic [4:0]         w_win_id;
  logic               w_unused;

  assign w_unused = ^{hsize_i, hburst_i, haddr_i[AWIDTH-1:5]};

  assign hreadyout_o = 1'b1;
  assign hresp_o     = 1'b0;
  assign irq_o       = r_irq;

  assign w_accept = hsel_i & hready_i & (htrans_i == HTRANS_NONSEQ);
  assign w_wr     = r_dp.valid & r_dp.write;
  assign w_rd     = r_dp.valid & ~r_dp.write;
  assign w_claim  = w_rd & (r_dp.off == OFF_CLAIM);
  assign w_complete = w_wr & (r_dp.off == OFF_COMPLETE);

  assign w_rise      = r_src_q & ~r_src_prev;
  assign w_pend      = (r_trigger & r_epend) | (~r_trigger & r_src_q);
  assign w_claimable = w_pend & r_enable & ~r_insvc;

  intc_prio_enc #(.N(NUM_SRC)) u_enc (
    .i_req   (w_claimable),
    .o_valid (w_win_vld),
    .o_id    (w_win_id)
  );

  // per-source clear masks from the current data phase
  always_comb begin
    w_pclr    = '0;
    w_clm_set = '0;
    w_cmp_clr = '0;
    if (w_wr && r_dp.off == OFF_PENDING) w_pclr = hwdata_i[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      w_clm_set[i] = w_claim & w_win_vld & (w_win_id == 5'(i));
      w_cmp_clr[i] = w_complete & (hwdata_i == DWIDTH'(i + 1));
    end
  end

  // edge pending: a new rise beats any clear in the same cycle
  assign w_epend_nxt = r_trigger &
    (w_rise | (r_epend & ~w_pclr & ~w_clm_set));

  assign w_insvc_nxt = (r_insvc & ~w_cmp_clr) | w_clm_set;

  // capture the address phase for the following data phase
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_dp <= '0;
    end else if (hready_i) begin
      r_dp.valid <= w_accept;
      r_dp.write <= hwrite_i;
      r_dp.off   <= haddr_i[4:0];
    end
  end

  // software-written configuration registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_enable  <= '0;
      r_trigger <= '0;
    end else if (w_wr) begin
      if (r_dp.off == OFF_ENABLE)  r_enable  <= hwdata_i[NUM_SRC-1:0];
      if (r_dp.off == OFF_TRIGGER) r_trigger <= hwdata_i[NUM_SRC-1:0];
    end
  end

  // source sampling, edge history and interrupt state
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_src_q    <= '0;
      r_src_prev <= '0;
      r_epend    <= '0;
      r_insvc    <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_src_q    <= irq_src_i;
      r_src_prev <= r_src_q;
      r_epend    <= w_epend_nxt;
      r_insvc    <= w_insvc_nxt;
      r_irq      <= |w_claimable;
    end
  end

  // read mux, driven only during a read data phase
  always_comb begin
    hrdata_o = '0;
    if (w_rd) begin
      case (r_dp.off)
        OFF_ENABLE:  hrdata_o = DWIDTH'(r_enable);
        OFF_PENDING: hrdata_o = DWIDTH'(w_pend);
        OFF_TRIGGER: hrdata_o = DWIDTH'(r_trigger);
        OFF_CLAIM:   hrdata_o = w_win_vld ? DWIDTH'(w_win_id + 5'd1) : '0;
        OFF_INSVC:   hrdata_o = DWIDTH'(r_insvc);
        default:     hrdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_intc.sv
// Self-checking bench for ahb_intc.
// Directed vectors plus random traffic vs a reference model.
module tb_ahb_intc;
  import ahb_intc_pkg::*;

  localparam int NS = 8;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          hsel_i, hwrite_i, hready_i;
  logic [2:0]    hsize_i, hburst_i;
  logic [1:0]    htrans_i;
  logic [31:0]   haddr_i, hwdata_i;
  logic          hreadyout_o, hresp_o;
  logic [31:0]   hrdata_o;
  logic [NS-1:0] irq_src_i;
  logic          irq_o;

  int checks = 0;
  int errors = 0;

  // reference model state (bit i = source i)
  logic [31:0] m_en, m_trig, m_ep, m_ins, m_q, m_prev;
  logic        m_irq;
  logic        m_dv, m_dw;
  logic [4:0]  m_doff;

  ahb_intc #(.AWIDTH(32), .DWIDTH(32), .NUM_SRC(NS)) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hsel_i      (hsel_i),
    .hwrite_i    (hwrite_i),
    .hready_i    (hready_i),
    .hsize_i     (hsize_i),
    .hburst_i    (hburst_i),
    .htrans_i    (htrans_i),
    .haddr_i     (haddr_i),
    .hwdata_i    (hwdata_i),
    .hreadyout_o (hreadyout_o),
    .hresp_o     (hresp_o),
    .hrdata_o    (hrdata_o),
    .irq_src_i   (irq_src_i),
    .irq_o       (irq_o)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pend(input int i);
    return m_trig[i] ? m_ep[i] : m_q[i];
  endfunction

  function automatic int m_winner();
    for (int i = 0; i < NS; i++)
      if (m_pend(i) && m_en[i] && !m_ins[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] off);
    logic [31:0] v = 0;
    int w;
    case (off)
      OFF_ENABLE:  v = m_en;
      OFF_TRIGGER: v = m_trig;
      OFF_INSVC:   v = m_ins;
      OFF_PENDING: for (int i = 0; i < NS; i++) v[i] = m_pend(i);
      OFF_CLAIM: begin
        w = m_winner();
        v = (w < 0) ? 0 : w + 1;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic m_reset();
    m_en = 0; m_trig = 0; m_ep = 0; m_ins = 0;
    m_q = 0; m_prev = 0; m_irq = 0;
    m_dv = 0; m_dw = 0; m_doff = 0;
  endtask

  // advance one clock: model next state from current state and inputs
  task automatic tick();
    logic [31:0] n_en, n_trig, n_ep, n_ins, pclr, exp_rd;
    int w, claimed;
    w = m_winner();
    claimed = -1;
    n_en = m_en; n_trig = m_trig; n_ep = m_ep; n_ins = m_ins;
    pclr = 0;
    if (m_dv && m_dw) begin
      case (m_doff)
        OFF_ENABLE:  n_en = hwdata_i & ((1 << NS) - 1);
        OFF_TRIGGER: n_trig = hwdata_i & ((1 << NS) - 1);
        OFF_PENDING: pclr = hwdata_i;
        OFF_COMPLETE:
          if (hwdata_i >= 1 && hwdata_i <= NS) n_ins[hwdata_i - 1] = 1'b0;
        default: ;
      endcase
    end
    if (m_dv && !m_dw && m_doff == OFF_CLAIM && w >= 0) begin
      n_ins[w] = 1'b1;
      claimed = w;
    end
    for (int i = 0; i < NS; i++) begin
      if (!m_trig[i]) n_ep[i] = 1'b0;
      else if (m_q[i] && !m_prev[i]) n_ep[i] = 1'b1;
      else if (pclr[i] || claimed == i) n_ep[i] = 1'b0;
    end
    @(posedge hclk);
    #1;
    m_irq = (w >= 0);
    m_prev = m_q;
    m_q = 32'(irq_src_i);
    m_dv = hsel_i && hready_i && htrans_i == HTRANS_NONSEQ;
    m_dw = hwrite_i;
    m_doff = haddr_i[4:0];
    m_en = n_en; m_trig = n_trig; m_ep = n_ep; m_ins = n_ins;
    exp_rd = (m_dv && !m_dw) ? m_read(m_doff) : 0;
    chk("irq_o", 32'(irq_o), 32'(m_irq));
    chk("hrdata", hrdata_o, exp_rd);
    chk("hready", {31'b0, hreadyout_o, hresp_o}, 32'h2);
  endtask

  task automatic idle_bus();
    hsel_i = 0; htrans_i = HTRANS_IDLE; hwrite_i = 0;
  endtask

  task automatic addr_phase(input logic [4:0] off, input logic wr,
                            input logic [1:0] tr);
    hsel_i = 1; htrans_i = tr; hwrite_i = wr;
    haddr_i = ($urandom & 32'hFFFF_FFE0) | 32'(off);
    hwdata_i = $urandom;
  endtask

  task automatic rd(input logic [4:0] off, input logic [1:0] tr,
                    output logic [31:0] v);
    addr_phase(off, 1'b0, tr);
    tick();
    v = hrdata_o;
    idle_bus();
    tick();
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d,
                    input logic [1:0] tr);
    addr_phase(off, 1'b1, tr);
    tick();
    idle_bus();
    hwdata_i = d;
    tick();
  endtask

  task automatic rdc(input string tag, input logic [4:0] off,
                     input logic [31:0] exp);
    logic [31:0] v;
    rd(off, HTRANS_NONSEQ, v);
    chk(tag, v, exp);
  endtask

  task automatic pulse(input logic [NS-1:0] s);
    irq_src_i = s;
    tick();
    irq_src_i = 0;
    tick();
    tick();
  endtask

  initial begin
    logic [31:0] v;
    int op;
    logic [1:0] tr;
    hresetn = 0; irq_src_i = 0; hready_i = 1;
    hsize_i = HSIZE_WORD; hburst_i = HBURST_SINGLE;
    haddr_i = 0; hwdata_i = 0;
    idle_bus();
    m_reset();
    #12;
    chk("rst_irq", 32'(irq_o), 0);
    chk("rst_rdata", hrdata_o, 0);
    chk("rst_ready", 32'(hreadyout_o), 1);
    #11 hresetn = 1;

    // single edge source through claim
    wr(OFF_TRIGGER, 32'hFF, HTRANS_NONSEQ);
    wr(OFF_ENABLE, 32'h01, HTRANS_NONSEQ);
    irq_src_i = 8'h01;
    tick();
    irq_src_i = 0;
    tick();
    chk("t1_irq_early", 32'(irq_o), 0);
    tick();
    chk("t1_irq", 32'(irq_o), 1);
    rdc("t1_pend", OFF_PENDING, 32'h01);
    rdc("t1_claim", OFF_CLAIM, 32'd1);
    rdc("t1_pend0", OFF_PENDING, 32'h00);
    rdc("t1_insvc", OFF_INSVC, 32'h01);
    chk("t1_irq_off", 32'(irq_o), 0);

    // two simultaneous edges
    wr(OFF_COMPLETE, 32'd1, HTRANS_NONSEQ);
    wr(OFF_ENABLE, 32'h0C, HTRANS_NONSEQ);
    pulse(8'h0C);
    rdc("t2_claim3", OFF_CLAIM, 32'd3);
    rdc("t2_claim4", OFF_CLAIM, 32'd4);
    rdc("t2_claim0", OFF_CLAIM, 32'd0);
    wr(OFF_COMPLETE, 32'd3, HTRANS_NONSEQ);
    rdc("t2_insvc", OFF_INSVC, 32'h08);

    // level source
    wr(OFF_COMPLETE, 32'd4, HTRANS_NONSEQ);
    wr(OFF_TRIGGER, 32'h00, HTRANS_NONSEQ);
    wr(OFF_ENABLE, 32'h02, HTRANS_NONSEQ);
    irq_src_i = 8'h02;
    tick();
    tick();
    rdc("t3_claim", OFF_CLAIM, 32'd2);
    wr(OFF_COMPLETE, 32'd2, HTRANS_NONSEQ);
    tick();
    chk("t3_irq_re", 32'(irq_o), 1);
    irq_src_i = 0;
    tick();
    rdc("t3_pend0", OFF_PENDING, 32'h00);

    // edge set collides with write-1-to-clear
    wr(OFF_TRIGGER, 32'hFF, HTRANS_NONSEQ);
    wr(OFF_ENABLE, 32'h00, HTRANS_NONSEQ);
    pulse(8'h01);
    addr_phase(OFF_PENDING, 1'b1, HTRANS_NONSEQ);
    irq_src_i = 8'h01;
    tick();
    idle_bus();
    irq_src_i = 0;
    hwdata_i = 32'h01;
    tick();
    rdc("t4_pend_set", OFF_PENDING, 32'h01);

    // unmapped and out-of-range accesses
    wr(OFF_ENABLE, 32'h01, HTRANS_NONSEQ);
    rdc("t5_claim", OFF_CLAIM, 32'd1);
    rdc("t5_unmapped", 5'h18, 32'h0);
    wr(OFF_COMPLETE, 32'h20, HTRANS_NONSEQ);
    rdc("t5_insvc", OFF_INSVC, 32'h01);

    // reset during a claim data phase
    wr(OFF_COMPLETE, 32'd1, HTRANS_NONSEQ);
    pulse(8'h01);
    addr_phase(OFF_CLAIM, 1'b0, HTRANS_NONSEQ);
    tick();
    idle_bus();
    hresetn = 0;
    #2;
    m_reset();
    chk("t6_irq", 32'(irq_o), 0);
    chk("t6_rdata", hrdata_o, 0);
    #2 hresetn = 1;
    rdc("t6_insvc", OFF_INSVC, 32'h0);
    chk("t6_ready", 32'(hreadyout_o), 1);

    // random traffic against the model
    wr(OFF_TRIGGER, $urandom, HTRANS_NONSEQ);
    wr(OFF_ENABLE, $urandom, HTRANS_NONSEQ);
    for (int n = 0; n < 400; n++) begin
      irq_src_i = NS'($urandom);
      op = $urandom_range(0, 7);
      tr = ($urandom_range(0, 4) == 0) ? 2'($urandom) : HTRANS_NONSEQ;
      case (op)
        0: tick();
        1: rd(5'($urandom_range(0, 7) * 4), tr, v);
        2: wr(OFF_ENABLE, $urandom, tr);
        3: wr(OFF_PENDING, $urandom, tr);
        4: wr(OFF_COMPLETE, $urandom_range(0, 10), tr);
        5: wr(OFF_TRIGGER, $urandom, tr);
        default: rd(OFF_CLAIM, tr, v);
      endcase
    end
    idle_bus();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_intc.md
AHB_INTC -- requirements
Module: ahb_intc

Interface
REQ-001 Parameter AWIDTH, 32: AHB address width.
REQ-002 Parameter DWIDTH, 32: AHB data width.
REQ-003 Parameter NUM_SRC, 8: interrupt source count, 1..31; source 0 = ahb_timer timer_irq_o.
REQ-004 hclk  in  1  single clock; all logic on rising edge.
REQ-005 hresetn  in  1  reset, asynchronous, active-low.
REQ-006 hsel_i, hwrite_i, hready_i  in  1 each  AHB-Lite slave select, write, bus ready.
REQ-007 hsize_i, hburst_i  in  3 each  AHB size and burst; only word and SINGLE are supported.
REQ-008 htrans_i  in  2  AHB transfer type.
REQ-009 haddr_i  in  AWIDTH  address; offset = haddr_i[4:0].
REQ-010 hwdata_i  in  DWIDTH  write data, valid in data phase.
REQ-011 hreadyout_o  out  1  slave ready; hresp_o  out  1  response; hrdata_o  out  DWIDTH  read data.
REQ-012 irq_src_i  in  NUM_SRC  interrupt requests, synchronous to hclk.
REQ-013 irq_o  out  1  interrupt request to core.

Function
REQ-014 Address phase is accepted when hsel_i && hready_i && htrans_i == NONSEQ; hwrite, offset and a valid flag are registered for the data phase in the next cycle.
REQ-015 Zero wait states: hreadyout_o = 1 and hresp_o = 0 at all times.
REQ-016 hrdata_o is combinational from the registered offset during a valid read data phase, and 0 otherwise.
REQ-017 Writes take effect at the clock edge that ends the data phase.
REQ-018 Register map: 0x00 ENABLE RW; 0x04 PENDING RO, write-1-to-clear edge bits; 0x08 TRIGGER RW (1 = edge, 0 = level); 0x0C CLAIM RO; 0x10 COMPLETE WO; 0x14 INSERVICE RO.
REQ-019 Unmapped offsets read 0 and ignore writes; bits at and above NUM_SRC read 0.
REQ-020 src_q is irq_src_i registered once.
REQ-021 Edge pending bit: set when src_q rises (src_q = 1, previous = 0); held until cleared.
REQ-022 Level pending bit: equals src_q; PENDING write has no effect on it.
REQ-023 Edge set and clear in the same cycle: set wins.
REQ-024 Claimable = pending & enable & ~inservice; winner = lowest index set.
REQ-025 CLAIM read returns winner+1, or 0 if none.
REQ-026 At the end of a CLAIM read data phase: set inservice[winner]; clear pending[winner] if that source is edge-triggered.
REQ-027 Winner is evaluated in the data-phase cycle, from the same vector that drives hrdata_o.
REQ-028 COMPLETE write of value k (1..NUM_SRC) clears inservice[k-1]; 0 or out-of-range values are ignored.
REQ-029 CLAIM and COMPLETE of the same id in one cycle is not possible; COMPLETE followed by a CLAIM in the next cycle sees the cleared bit.
REQ-030 irq_o is registered: irq_o <= |claimable, so it follows pending by 1 cycle.
REQ-031 Changing TRIGGER from edge to level makes pending follow src_q from the next cycle.

Reset
REQ-032 hresetn low, asynchronously: ENABLE, TRIGGER, pending, inservice, src_q, edge history and data-phase valid all = 0; irq_o = 0; hrdata_o = 0.
REQ-033 Reset asserted mid-transfer aborts it with no register side effect; the first cycle after release accepts a new address phase.

Structure
REQ-034 Package ahb_intc_pkg holds: HTRANS/HBURST constants, register offset constants, and the NUM_SRC default.
REQ-035 Sub-module intc_prio_enc: combinational lowest-index encoder, input NUM_SRC bits, outputs valid and id; instantiated once.

Verification
REQ-036 All sources edge-triggered, ENABLE = 0x01, pulse src0 for 1 cycle -> PENDING = 0x01; irq_o = 1 two cycles after the pulse; CLAIM read = 1; PENDING = 0; INSERVICE = 0x01; irq_o = 0.
REQ-037 ENABLE = 0x0C, edge pulses on src2 and src3 in the same cycle -> CLAIM = 3, then CLAIM = 4, then CLAIM = 0; COMPLETE 3 -> INSERVICE = 0x08.
REQ-038 TRIGGER = 0, ENABLE = 0x02, hold src1 high -> CLAIM = 2; COMPLETE 2 while src1 still high -> irq_o re-asserts; drop src1 -> PENDING = 0 one cycle later.
REQ-039 Edge on src0 in the same cycle as a PENDING write of 0x01 -> PENDING bit stays 1.
REQ-040 Assert hresetn low during a CLAIM data phase -> INSERVICE = 0 and irq_o = 0; first transfer after release completes with hreadyout_o = 1.
REQ-041 Read offset 0x18 -> 0; COMPLETE write of 0x20 -> no state change.
